m_axi_image_loader: RTL and testbench

M_AXI_IMAGE_LOADER -- requirements
Module: m_axi_image_loader

---
 rtl/m_axi_image_loader_if.sv | 55 +++++
 rtl/m_axi_image_loader.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_m_axi_image_loader.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/m_axi_image_loader_if.sv
// ---------------------------------------------------------------------------
// m_axi_image_loader_if
//   AXI4-Lite style bus bundle used by the image loader. The loader is the
//   master; the memory-mapped inference accelerator is the slave.
//
//   Write address : AWADDR, AWVALID (m->s), AWREADY (s->m)
//   Write data    : WDATA, WSTRB, WVALID (m->s), WREADY (s->m)
//   Write response: BRESP, BVALID (s->m), BREADY (m->s)
//   Read address  : ARADDR, ARVALID (m->s), ARREADY (s->m)
//   Read data     : RDATA, RRESP, RVALID (s->m), RREADY (m->s)
// ---------------------------------------------------------------------------
interface m_axi_image_loader_if #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32
);

  logic [AXI_ADDR_WIDTH-1:0] AWADDR;
  logic                      AWVALID;
  logic                      AWREADY;

  logic [AXI_DATA_WIDTH-1:0] WDATA;
  logic [3:0]                WSTRB;
  logic                      WVALID;
  logic                      WREADY;

  logic [1:0]                BRESP;
  logic                      BVALID;
  logic                      BREADY;

  logic [AXI_ADDR_WIDTH-1:0] ARADDR;
  logic                      ARVALID;
  logic                      ARREADY;

  logic [AXI_DATA_WIDTH-1:0] RDATA;
  logic [1:0]                RRESP;
  logic                      RVALID;
  logic                      RREADY;

  modport master (
    output AWADDR, AWVALID, input  AWREADY,
    output WDATA,  WSTRB,   WVALID, input WREADY,
    input  BRESP,  BVALID,  output BREADY,
    output ARADDR, ARVALID, input  ARREADY,
    input  RDATA,  RRESP,   RVALID, output RREADY
  );

  modport slave (
    input  AWADDR, AWVALID, output AWREADY,
    input  WDATA,  WSTRB,   WVALID, output WREADY,
    output BRESP,  BVALID,  input  BREADY,
    input  ARADDR, ARVALID, output ARREADY,
    output RDATA,  RRESP,   RVALID, input  RREADY
  );

endinterface

// File: rtl/m_axi_image_loader.sv
// ---------------------------------------------------------------------------
// m_axi_image_loader
//   Streams an image from a local pixel RAM into an accelerator over AXI-Lite,
//   kicks the accelerator through its control register (write 1, then 0) and
//   polls the result register until bit 31 reports a valid digit.
//
//   Ports
//     CLK, RST   clock, synchronous active-high reset
//     START      one-cycle pulse that begins a transfer (ignored while BUSY)
//     PIX_ADDR   pixel RAM address; PIX_DATA is valid one cycle later
//     PIX_DATA   pixel RAM read data
//     axi        AXI-Lite master bus (see m_axi_image_loader_if)
//     BUSY       transfer in progress (any state except IDLE)
//     DONE       one-cycle completion pulse
//     DIGIT      inferred digit, held until the next START
//     ERROR      a non-OKAY response was seen, held until the next START
//
//   Only one AXI transaction is ever outstanding: a new address is issued only
//   after the previous write response / read data has been accepted.
// ---------------------------------------------------------------------------
module m_axi_image_loader #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int IMAGE_SIZE     = 256,
  parameter int PIXEL_BITS     = 8,
  parameter int CTRL_ADDR      = 256,
  parameter int RESULT_ADDR    = 0,
  parameter int POLL_GAP       = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          START,
  output logic [$clog2(IMAGE_SIZE)-1:0] PIX_ADDR,
  input  logic [PIXEL_BITS-1:0]         PIX_DATA,
  m_axi_image_loader_if.master          axi,
  output logic                          BUSY,
  output logic                          DONE,
  output logic [7:0]                    DIGIT,
  output logic                          ERROR
);

  localparam int IDX_W = $clog2(IMAGE_SIZE);
  localparam int PCW   = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    WRITE,
    WRESP,
    CTRL_SET,
    CTRL_CLR,
    RADDR,
    RDATA,
    POLL_WAIT,
    FINISH
  } state_e;

  // Which write the shared WRESP state is waiting on.
  typedef enum logic [1:0] {
    WK_PIXEL,
    WK_SET,
    WK_CLR
  } wr_kind_e;

  state_e                    state_q,      state_d;
  wr_kind_e                  wr_kind_q,    wr_kind_d;
  logic [IDX_W-1:0]          index_q,      index_d;
  logic                      fetch_wait_q, fetch_wait_d;
  logic [PCW-1:0]            poll_cnt_q,   poll_cnt_d;

  logic [AXI_ADDR_WIDTH-1:0] awaddr_q,     awaddr_d;
  logic                      awvalid_q,    awvalid_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q,      wdata_d;
  logic                      wvalid_q,     wvalid_d;
  logic                      bready_q,     bready_d;
  logic [AXI_ADDR_WIDTH-1:0] araddr_q,     araddr_d;
  logic                      arvalid_q,    arvalid_d;
  logic                      rready_q,     rready_d;

  logic [7:0]                digit_q,      digit_d;
  logic                      error_q,      error_d;

  logic                      aw_hs;
  logic                      w_hs;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register, independent of
  // statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      wr_kind_q    <= WK_PIXEL;
      index_q      <= '0;
      fetch_wait_q <= 1'b0;
      poll_cnt_q   <= '0;
      awaddr_q     <= '0;
      awvalid_q    <= 1'b0;
      wdata_q      <= '0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      araddr_q     <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      digit_q      <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_kind_q    <= wr_kind_d;
      index_q      <= index_d;
      fetch_wait_q <= fetch_wait_d;
      poll_cnt_q   <= poll_cnt_d;
      awaddr_q     <= awaddr_d;
      awvalid_q    <= awvalid_d;
      wdata_q      <= wdata_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      araddr_q     <= araddr_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      digit_q      <= digit_d;
      error_q      <= error_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  assign aw_hs = awvalid_q & axi.AWREADY;
  assign w_hs  = wvalid_q  & axi.WREADY;

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    wr_kind_d    = wr_kind_q;
    index_d      = index_q;
    fetch_wait_d = fetch_wait_q;
    poll_cnt_d   = poll_cnt_q;
    awaddr_d     = awaddr_q;
    awvalid_d    = awvalid_q;
    wdata_d      = wdata_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    araddr_d     = araddr_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    digit_d      = digit_q;
    error_d      = error_q;

    unique case (state_q)
      IDLE: begin
        if (START) begin
          state_d      = FETCH;
          index_d      = '0;
          fetch_wait_d = 1'b0;
          error_d      = 1'b0;
          digit_d      = '0;
        end
      end

      // First cycle presents PIX_ADDR; the RAM answers on the second, where
      // the pixel is captured and both write channels are raised together.
      FETCH: begin
        if (!fetch_wait_q) begin
          fetch_wait_d = 1'b1;
        end else begin
          fetch_wait_d = 1'b0;
          awaddr_d     = AXI_ADDR_WIDTH'(index_q);
          wdata_d      = AXI_DATA_WIDTH'(PIX_DATA);
          awvalid_d    = 1'b1;
          wvalid_d     = 1'b1;
          wr_kind_d    = WK_PIXEL;
          state_d      = WRITE;
        end
      end

      // AW and W complete independently; each VALID drops after its own
      // handshake. BREADY is raised only once both channels are accepted.
      WRITE, CTRL_SET, CTRL_CLR: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) begin
          bready_d = 1'b1;
          state_d  = WRESP;
        end
      end

      WRESP: begin
        if (bready_q && axi.BVALID) begin
          bready_d = 1'b0;
          if (axi.BRESP != 2'b00) begin
            error_d = 1'b1;
            state_d = FINISH;
          end else begin
            unique case (wr_kind_q)
              WK_PIXEL: begin
                if (index_q != IDX_W'(IMAGE_SIZE - 1)) begin
                  index_d = index_q + IDX_W'(1);
                  state_d = FETCH;
                end else begin
                  awaddr_d  = AXI_ADDR_WIDTH'(CTRL_ADDR);
                  wdata_d   = AXI_DATA_WIDTH'(1);
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  wr_kind_d = WK_SET;
                  state_d   = CTRL_SET;
                end
              end
              WK_SET: begin
                awaddr_d  = AXI_ADDR_WIDTH'(CTRL_ADDR);
                wdata_d   = '0;
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
                wr_kind_d = WK_CLR;
                state_d   = CTRL_CLR;
              end
              default: begin
                araddr_d  = AXI_ADDR_WIDTH'(RESULT_ADDR);
                arvalid_d = 1'b1;
                state_d   = RADDR;
              end
            endcase
          end
        end
      end

      RADDR: begin
        if (axi.ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDATA;
        end
      end

      // Bit 31 of the result register flags a finished inference.
      RDATA: begin
        if (rready_q && axi.RVALID) begin
          rready_d = 1'b0;
          if (axi.RRESP != 2'b00) begin
            error_d = 1'b1;
            state_d = FINISH;
          end else if (axi.RDATA[31]) begin
            digit_d = axi.RDATA[7:0];
            state_d = FINISH;
          end else if (POLL_GAP == 0) begin
            araddr_d  = AXI_ADDR_WIDTH'(RESULT_ADDR);
            arvalid_d = 1'b1;
            state_d   = RADDR;
          end else begin
            poll_cnt_d = '0;
            state_d    = POLL_WAIT;
          end
        end
      end

      // Exactly POLL_GAP idle cycles before the next result read.
      POLL_WAIT: begin
        if (poll_cnt_q == PCW'(POLL_GAP - 1)) begin
          araddr_d  = AXI_ADDR_WIDTH'(RESULT_ADDR);
          arvalid_d = 1'b1;
          state_d   = RADDR;
        end else begin
          poll_cnt_d = poll_cnt_q + PCW'(1);
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign PIX_ADDR    = index_q;

  assign axi.AWADDR  = awaddr_q;
  assign axi.AWVALID = awvalid_q;
  assign axi.WDATA   = wdata_q;
  // Only byte lane 0 carries data; the strobe is live only with WVALID.
  assign axi.WSTRB   = wvalid_q ? 4'b0001 : 4'b0000;
  assign axi.WVALID  = wvalid_q;
  assign axi.BREADY  = bready_q;
  assign axi.ARADDR  = araddr_q;
  assign axi.ARVALID = arvalid_q;
  assign axi.RREADY  = rready_q;

  assign BUSY        = (state_q != IDLE);
  assign DONE        = (state_q == FINISH);
  assign DIGIT       = digit_q;
  assign ERROR       = error_q;

endmodule

// File: tb/tb_m_axi_image_loader.sv
// ---------------------------------------------------------------------------
// tb_m_axi_image_loader
//   Self-checking bench: a reactive AXI-Lite slave plus pixel RAM model, a
//   write scoreboard filled when a transfer is started and drained on each
//   write response, and an expected-result queue drained on DONE.
// ---------------------------------------------------------------------------
module tb_m_axi_image_loader;

  localparam int IMAGE_SIZE  = 256;
  localparam int POLL_GAP    = 4;
  localparam int CTRL_ADDR   = 256;
  localparam int RESULT_ADDR = 0;
  localparam int BUDGET      = 5000;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] pix_addr;
  logic [7:0] pix_data;
  logic       busy;
  logic       done;
  logic [7:0] digit;
  logic       error;

  always #5 clk = ~clk;

  m_axi_image_loader_if #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32)) axi ();

  m_axi_image_loader #(
    .AXI_DATA_WIDTH(32),
    .AXI_ADDR_WIDTH(32),
    .IMAGE_SIZE    (IMAGE_SIZE),
    .PIXEL_BITS    (8),
    .CTRL_ADDR     (CTRL_ADDR),
    .RESULT_ADDR   (RESULT_ADDR),
    .POLL_GAP      (POLL_GAP)
  ) dut (
    .CLK     (clk),
    .RST     (rst),
    .START   (start),
    .PIX_ADDR(pix_addr),
    .PIX_DATA(pix_data),
    .axi     (axi),
    .BUSY    (busy),
    .DONE    (done),
    .DIGIT   (digit),
    .ERROR   (error)
  );

  // Counters and scoreboards
  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] exp_wr_q[$];   // {awaddr, wdata}
  logic [8:0]  exp_res_q[$];  // {error, digit}
  logic [33:0] rd_rsp_q[$];   // {rresp, rdata}

  // Slave / monitor state
  int          cyc = 0;
  int          aw_delay = 1;
  int          err_idx = -1;
  int          pix_mode = 0;
  int          wr_count = 0;
  int          ar_count = 0;
  int          done_cnt = 0;
  int          viol = 0;
  int          len_bad = 0;
  int          aw_run = 0;
  int          w_run = 0;
  int          r_hs_cyc = -1;
  logic        aw_done = 1'b0;
  logic        w_done = 1'b0;
  logic        r_pend = 1'b0;
  logic        aw_stall = 1'b0;
  logic        w_stall = 1'b0;
  logic [31:0] aw_stall_addr;
  logic [31:0] w_stall_data;
  logic [31:0] cap_awaddr;
  logic [31:0] cap_wdata;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic [7:0]  pix_addr_s = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pixel(input int mode, input int a);
    return (mode == 0) ? 8'(a) : 8'(a * 37 + 11);
  endfunction

  // Sampled between edges: what is seen here is what the next rising edge uses.
  task automatic sample_bus();
    logic [63:0] e;
    logic [33:0] rsp;
    cyc++;
    if (axi.WSTRB != (axi.WVALID ? 4'b0001 : 4'b0000)) viol++;
    if (axi.AWVALID && aw_done) viol++;
    if (axi.WVALID && w_done) viol++;
    if (axi.BREADY && !(aw_done && w_done)) viol++;
    if (axi.ARVALID && (aw_done || w_done || r_pend)) viol++;
    if ((axi.AWVALID || axi.WVALID) && r_pend) viol++;
    if (aw_stall && (!axi.AWVALID || axi.AWADDR != aw_stall_addr)) viol++;
    if (w_stall && (!axi.WVALID || axi.WDATA != w_stall_data || axi.WSTRB != 4'b0001)) viol++;

    if (axi.AWVALID) aw_run++;
    if (axi.AWVALID && axi.AWREADY) begin
      aw_done    = 1'b1;
      cap_awaddr = axi.AWADDR;
      if (aw_run != aw_delay) len_bad++;
      aw_run = 0;
    end
    aw_stall      = axi.AWVALID && !axi.AWREADY;
    aw_stall_addr = axi.AWADDR;

    if (axi.WVALID) w_run++;
    if (axi.WVALID && axi.WREADY) begin
      w_done    = 1'b1;
      cap_wdata = axi.WDATA;
      if (w_run != 1) len_bad++;
      w_run = 0;
    end
    w_stall      = axi.WVALID && !axi.WREADY;
    w_stall_data = axi.WDATA;

    if (axi.BVALID && axi.BREADY) begin
      // An all-ones entry stands for "no further write expected".
      e = (exp_wr_q.size() != 0) ? exp_wr_q.pop_front() : '1;
      check("wr_addr", cap_awaddr, e[63:32]);
      check("wr_data", cap_wdata, e[31:0]);
      wr_count++;
      aw_done = 1'b0;
      w_done  = 1'b0;
    end

    if (axi.ARVALID && axi.ARREADY) begin
      ar_count++;
      check("araddr", axi.ARADDR, RESULT_ADDR);
      if (r_hs_cyc >= 0) check("poll_gap", cyc - r_hs_cyc, POLL_GAP + 1);
      rsp     = (rd_rsp_q.size() != 0) ? rd_rsp_q.pop_front() : {2'b00, 32'h8000_00FF};
      r_pend  = 1'b1;
      r_rresp = rsp[33:32];
      r_rdata = rsp[31:0];
    end
    if (axi.RVALID && axi.RREADY) begin
      r_pend   = 1'b0;
      r_hs_cyc = cyc;
    end

    if (done) begin
      done_cnt++;
      e[8:0] = (exp_res_q.size() != 0) ? exp_res_q.pop_front() : 9'h1FF;
      check("done_error", error, e[8]);
      check("done_digit", digit, e[7:0]);
      check("done_busy", busy, 1);
    end
    pix_addr_s = pix_addr;
  endtask

  // Driven just after the rising edge so inputs are stable around the next one.
  task automatic drive_bus();
    axi.AWREADY = axi.AWVALID && (aw_run + 1 >= aw_delay);
    axi.WREADY  = 1'b1;
    axi.BVALID  = aw_done && w_done;
    axi.BRESP   = (aw_done && w_done && wr_count == err_idx) ? 2'b10 : 2'b00;
    axi.ARREADY = 1'b1;
    axi.RVALID  = r_pend;
    axi.RDATA   = r_pend ? r_rdata : 32'h0;
    axi.RRESP   = r_pend ? r_rresp : 2'b00;
    pix_data    = pixel(pix_mode, int'(pix_addr_s));
  endtask

  initial begin
    axi.AWREADY = 1'b0;
    axi.WREADY  = 1'b0;
    axi.BVALID  = 1'b0;
    axi.BRESP   = 2'b00;
    axi.ARREADY = 1'b0;
    axi.RVALID  = 1'b0;
    axi.RDATA   = '0;
    axi.RRESP   = 2'b00;
    pix_data    = '0;
    forever begin
      @(negedge clk);
      sample_bus();
      @(posedge clk);
      #1;
      drive_bus();
    end
  end

  task automatic flush_slave();
    exp_wr_q.delete();
    exp_res_q.delete();
    rd_rsp_q.delete();
    aw_done  = 1'b0;
    w_done   = 1'b0;
    r_pend   = 1'b0;
    aw_run   = 0;
    w_run    = 0;
    aw_stall = 1'b0;
    w_stall  = 1'b0;
    r_hs_cyc = -1;
  endtask

  task automatic check_reset_values();
    check("rst_awvalid", axi.AWVALID, 0);
    check("rst_wvalid",  axi.WVALID,  0);
    check("rst_bready",  axi.BREADY,  0);
    check("rst_arvalid", axi.ARVALID, 0);
    check("rst_rready",  axi.RREADY,  0);
    check("rst_wstrb",   axi.WSTRB,   0);
    check("rst_awaddr",  axi.AWADDR,  0);
    check("rst_wdata",   axi.WDATA,   0);
    check("rst_araddr",  axi.ARADDR,  0);
    check("rst_pixaddr", pix_addr,    0);
    check("rst_busy",    busy,        0);
    check("rst_done",    done,        0);
    check("rst_error",   error,       0);
    check("rst_digit",   digit,       0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    flush_slave();
    check_reset_values();
  endtask

  // Loads the scoreboards for one transfer; rd_rsp_q must already hold the
  // result-register responses. Returns expected write and AR counts.
  task automatic arm(input int mode, input int delay, input int err,
                     output int n_wr, output int n_ar, output logic [8:0] res);
    bit found;
    wr_count = 0;
    ar_count = 0;
    viol     = 0;
    len_bad  = 0;
    r_hs_cyc = -1;
    pix_mode = mode;
    aw_delay = delay;
    err_idx  = err;
    exp_wr_q.delete();
    exp_res_q.delete();
    for (int i = 0; i < IMAGE_SIZE; i++) begin
      if (err >= 0 && i > err) break;
      exp_wr_q.push_back({32'(i), 32'(pixel(mode, i))});
    end
    if (err < 0) begin
      exp_wr_q.push_back({32'(CTRL_ADDR), 32'h1});
      exp_wr_q.push_back({32'(CTRL_ADDR), 32'h0});
    end
    n_wr  = exp_wr_q.size();
    n_ar  = 0;
    res   = {1'b1, 8'h00};
    found = 1'b0;
    if (err < 0) begin
      foreach (rd_rsp_q[k]) begin
        if (!found) begin
          if (rd_rsp_q[k][33:32] != 2'b00) begin
            res = {1'b1, 8'h00}; found = 1'b1; n_ar = k + 1;
          end else if (rd_rsp_q[k][31]) begin
            res = {1'b0, rd_rsp_q[k][7:0]}; found = 1'b1; n_ar = k + 1;
          end
        end
      end
    end
    exp_res_q.push_back(res);
  endtask

  task automatic run(input string name, input int mode, input int delay,
                     input int err, input int restart_at);
    int          n_wr;
    int          n_ar;
    int          d0;
    int          cnt;
    logic [8:0]  res;
    arm(mode, delay, err, n_wr, n_ar, res);
    d0    = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy_start"}, busy, 1);
    cnt = 0;
    while (done_cnt == d0 && cnt < BUDGET) begin
      @(negedge clk);
      cnt++;
      start = (cnt == restart_at);
    end
    start = 1'b0;
    check({name, "_done_seen"}, done_cnt != d0, 1);
    repeat (10) @(negedge clk);
    check({name, "_done_count"}, done_cnt - d0, 1);
    check({name, "_busy_idle"}, busy, 0);
    check({name, "_wr_count"}, wr_count, n_wr);
    check({name, "_wr_left"}, exp_wr_q.size(), 0);
    check({name, "_ar_count"}, ar_count, n_ar);
    check({name, "_protocol"}, viol, 0);
    check({name, "_hs_len"}, len_bad, 0);
    check({name, "_error_hold"}, error, res[8]);
    check({name, "_digit_hold"}, digit, res[7:0]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n_wr;
    int          n_ar;
    int          cnt;
    logic [8:0]  res;
    bit          hit;

    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values();
    rst = 1'b0;

    // Plain image, always-ready slave; START right after reset release.
    rd_rsp_q.push_back({2'b00, 32'h8000_0005});
    run("basic", 0, 1, -1, 0);
    pulse_reset();

    // Slow write-address channel with a scrambled image.
    rd_rsp_q.push_back({2'b00, 32'h8000_0007});
    run("awdelay", 1, 3, -1, 0);

    // Result not ready twice before the digit appears.
    rd_rsp_q.push_back({2'b00, 32'h0000_0000});
    rd_rsp_q.push_back({2'b00, 32'h0000_0000});
    rd_rsp_q.push_back({2'b00, 32'h8000_0003});
    run("poll", 0, 1, -1, 0);

    // Slave error on pixel 10 aborts the transfer.
    run("bresp", 0, 1, 10, 0);
    pulse_reset();

    // Slave error on the result read.
    rd_rsp_q.push_back({2'b10, 32'h8000_0009});
    run("rresp", 1, 1, -1, 0);

    // START pulsed mid-transfer must be ignored.
    rd_rsp_q.push_back({2'b00, 32'h8000_0001});
    run("restart", 0, 1, -1, 100);

    // Reset while pixel 50 is on the address channel, then a fresh transfer.
    arm(0, 1, -1, n_wr, n_ar, res);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    cnt = 0;
    while (!hit && cnt < BUDGET) begin
      @(negedge clk);
      cnt++;
      hit = axi.AWVALID && (axi.AWADDR == 32'd50);
    end
    check("midrst_reach_px50", hit, 1);
    pulse_reset();
    rd_rsp_q.push_back({2'b00, 32'h8000_0002});
    run("after_rst", 0, 1, -1, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
